ad9970_line_decode: RTL and testbench

- Sits directly downstream of the AD9970 LVDS deserializer (ccd_deser_cut).
- Consumes the recovered 16-bit parallel word stream and hunts for the AD9970 sync sequence, which is SYNC_NUM consecutive copies of SYNC_WORD.
- Once a sync sequence is found, it extracts exactly iv_line_length pixel words per line as right-aligned 14-bit data, and produces o_lval, a line-lock status and error pulses for the downstream video pipeline.

---
 rtl/ad9970_line_decode_pkg.sv | 17 +
 rtl/ad9970_line_decode_if.sv | 29 ++
 rtl/ad9970_line_decode_sync_hunt.sv | 65 ++++++
 rtl/ad9970_line_decode.sv | 171 +++++++++++++++++
 tb/tb_ad9970_line_decode.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ad9970_line_decode_pkg.sv
// Shared definitions for the AD9970 line decoder: sync pattern defaults,
// datapath widths and the line FSM state encoding.
package ad9970_line_decode_pkg;

  localparam logic [15:0] DEF_SYNC_WORD  = 16'h8421;
  localparam int          DEF_SYNC_NUM   = 7;
  localparam int          DEF_DATA_WD    = 14;
  localparam int          DEF_LINE_WD    = 13;
  localparam int          DEF_LOCK_LINES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_LINE = 2'd2
  } state_e;

endpackage

// File: rtl/ad9970_line_decode_if.sv
// Word-stream input and decoded-pixel output bundle of the AD9970 line decoder.
interface ad9970_line_decode_if
  import ad9970_line_decode_pkg::*;
#(
  parameter int DATA_WD = DEF_DATA_WD,
  parameter int LINE_WD = DEF_LINE_WD
);

  logic               i_start_acquisit;
  logic               i_word_valid;
  logic [15:0]        iv_word;
  logic [LINE_WD-1:0] iv_line_length;
  logic [DATA_WD-1:0] ov_pix_data;
  logic               o_lval;
  logic               o_sync_lock;
  logic               o_sync_err;
  logic [15:0]        ov_line_cnt;

  modport master (
    output i_start_acquisit, i_word_valid, iv_word, iv_line_length,
    input  ov_pix_data, o_lval, o_sync_lock, o_sync_err, ov_line_cnt
  );

  modport slave (
    input  i_start_acquisit, i_word_valid, iv_word, iv_line_length,
    output ov_pix_data, o_lval, o_sync_lock, o_sync_err, ov_line_cnt
  );

endinterface

// File: rtl/ad9970_line_decode_sync_hunt.sv
// Counts consecutive sync words. Flags completion of a full sync run and
// the end of a partial run broken by a non-sync word.
module ad9970_sync_hunt
  import ad9970_line_decode_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int          SYNC_NUM  = DEF_SYNC_NUM
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,          // abandon any run in progress
  input  logic        en,           // qualified word while hunting
  input  logic        preload,      // premature sync inside a line counts as match 1
  input  logic [15:0] word,
  output logic        sync_done,
  output logic        partial_err
);

  localparam int CNT_WD = (SYNC_NUM > 2) ? $clog2(SYNC_NUM) : 1;

  logic [CNT_WD-1:0] sync_cnt_r;
  logic [CNT_WD-1:0] sync_cnt_s;
  logic              match_s;

  // Next run length and the completion / broken-run flags.
  always_comb begin
    match_s     = (word == SYNC_WORD);
    sync_cnt_s  = sync_cnt_r;
    sync_done   = 1'b0;
    partial_err = 1'b0;
    if (clr) begin
      sync_cnt_s = {CNT_WD{1'b0}};
    end else if (preload) begin
      sync_cnt_s = CNT_WD'(1);
    end else if (en) begin
      if (match_s) begin
        if (sync_cnt_r == CNT_WD'(SYNC_NUM - 1)) begin
          sync_done  = 1'b1;
          sync_cnt_s = {CNT_WD{1'b0}};
        end else begin
          sync_cnt_s = sync_cnt_r + CNT_WD'(1);
        end
      end else begin
        if (sync_cnt_r != {CNT_WD{1'b0}}) begin
          partial_err = 1'b1;
        end else begin
          partial_err = 1'b0;
        end
        sync_cnt_s = {CNT_WD{1'b0}};
      end
    end else begin
      sync_cnt_s = sync_cnt_r;
    end
  end

  // Run-length register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_cnt_r <= {CNT_WD{1'b0}};
    end else begin
      sync_cnt_r <= sync_cnt_s;
    end
  end

endmodule

// File: rtl/ad9970_line_decode.sv
// AD9970 line decoder: hunts for the sync run, then emits iv_line_length
// right-aligned pixels per line with line-lock tracking and error pulses.
module ad9970_line_decode
  import ad9970_line_decode_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD  = DEF_SYNC_WORD,
  parameter int          SYNC_NUM   = DEF_SYNC_NUM,
  parameter int          DATA_WD    = DEF_DATA_WD,
  parameter int          LINE_WD    = DEF_LINE_WD,
  parameter int          LOCK_LINES = DEF_LOCK_LINES
) (
  input  logic                 clk,
  input  logic                 reset,
  ad9970_line_decode_if.slave  bus
);

  localparam int GOOD_WD = $clog2(LOCK_LINES + 1);

  state_e             state_r, state_s;
  logic [LINE_WD-1:0] pix_cnt_r, pix_cnt_s;
  logic [LINE_WD-1:0] len_r, len_s;
  logic [GOOD_WD-1:0] good_r, good_s;
  logic               lock_r, lock_s;
  logic               lval_r, lval_s;
  logic               err_r, err_s;
  logic [15:0]        line_r, line_s;
  logic [DATA_WD-1:0] pix_r, pix_s;
  logic               is_sync_s, clr_s, hunt_en_s, preload_s;
  logic               sync_done_s, partial_err_s;
  logic               bad_s, good_line_s;

  // Hunter controls depend only on registered state, keeping them off the FSM loop.
  assign is_sync_s = (bus.iv_word == SYNC_WORD);
  assign clr_s     = ~bus.i_start_acquisit;
  assign hunt_en_s = bus.i_start_acquisit & bus.i_word_valid & (state_r == ST_HUNT);
  assign preload_s = bus.i_start_acquisit & bus.i_word_valid & (state_r == ST_LINE) & is_sync_s;

  ad9970_sync_hunt #(
    .SYNC_WORD (SYNC_WORD),
    .SYNC_NUM  (SYNC_NUM)
  ) u_sync_hunt (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr_s),
    .en          (hunt_en_s),
    .preload     (preload_s),
    .word        (bus.iv_word),
    .sync_done   (sync_done_s),
    .partial_err (partial_err_s)
  );

  // Next state, counters, lock bookkeeping and output register values.
  always_comb begin
    state_s     = state_r;
    pix_cnt_s   = pix_cnt_r;
    len_s       = len_r;
    good_s      = good_r;
    lock_s      = lock_r;
    line_s      = line_r;
    pix_s       = pix_r;
    lval_s      = 1'b0;
    err_s       = 1'b0;
    bad_s       = 1'b0;
    good_line_s = 1'b0;
    if (!bus.i_start_acquisit) begin
      state_s   = ST_IDLE;
      pix_cnt_s = {LINE_WD{1'b0}};
      len_s     = {LINE_WD{1'b0}};
      good_s    = {GOOD_WD{1'b0}};
      lock_s    = 1'b0;
      line_s    = 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_HUNT;
        end
        ST_HUNT: begin
          if (sync_done_s) begin
            if (bus.iv_line_length == {LINE_WD{1'b0}}) begin
              bad_s = 1'b1;
            end else begin
              len_s     = bus.iv_line_length;
              pix_cnt_s = {LINE_WD{1'b0}};
              state_s   = ST_LINE;
            end
          end else if (partial_err_s) begin
            bad_s = 1'b1;
          end else begin
            bad_s = 1'b0;
          end
        end
        ST_LINE: begin
          if (bus.i_word_valid) begin
            if (is_sync_s) begin
              bad_s   = 1'b1;
              state_s = ST_HUNT;
            end else begin
              lval_s    = 1'b1;
              pix_s     = bus.iv_word[DATA_WD-1:0];
              pix_cnt_s = pix_cnt_r + LINE_WD'(1);
              if (pix_cnt_s == len_r) begin
                good_line_s = 1'b1;
                state_s     = ST_HUNT;
              end else begin
                good_line_s = 1'b0;
              end
            end
          end else begin
            lval_s = 1'b0;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase

      if (bad_s) begin
        err_s  = 1'b1;
        good_s = {GOOD_WD{1'b0}};
        lock_s = 1'b0;
        if (lock_r) begin
          line_s = 16'd0;
        end else begin
          line_s = line_r;
        end
      end else if (good_line_s) begin
        line_s = line_r + 16'd1;
        if (good_r != GOOD_WD'(LOCK_LINES)) begin
          good_s = good_r + GOOD_WD'(1);
        end else begin
          good_s = good_r;
        end
        lock_s = (good_s == GOOD_WD'(LOCK_LINES));
      end else begin
        line_s = line_r;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      pix_cnt_r <= {LINE_WD{1'b0}};
      len_r     <= {LINE_WD{1'b0}};
      good_r    <= {GOOD_WD{1'b0}};
      lock_r    <= 1'b0;
      line_r    <= 16'd0;
      pix_r     <= {DATA_WD{1'b0}};
      lval_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      pix_cnt_r <= pix_cnt_s;
      len_r     <= len_s;
      good_r    <= good_s;
      lock_r    <= lock_s;
      line_r    <= line_s;
      pix_r     <= pix_s;
      lval_r    <= lval_s;
      err_r     <= err_s;
    end
  end

  assign bus.ov_pix_data = pix_r;
  assign bus.o_lval      = lval_r;
  assign bus.o_sync_lock = lock_r;
  assign bus.o_sync_err  = err_r;
  assign bus.ov_line_cnt = line_r;

endmodule

// File: tb/tb_ad9970_line_decode.sv
// Self-checking bench for ad9970_line_decode: directed scenarios plus a
// randomized soak, compared every cycle against a behavioural line model.
module tb_ad9970_line_decode;
  import ad9970_line_decode_pkg::*;

  localparam logic [15:0] SW = 16'h8421;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ad9970_line_decode_if bus ();

  ad9970_line_decode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model state: mode 0 idle, 1 hunting, 2 inside a line.
  int          m_mode, m_run, m_remain, m_good;
  bit          m_lock;
  logic [15:0] m_lines;
  bit          e_lval, e_err;
  logic [13:0] e_pix;

  // Observations gathered by the compare process.
  logic [13:0] cap[$];
  int          err_seen, lval_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_err();
    e_err = 1'b1;
    if (m_lock) m_lines = 16'd0;
    m_lock = 1'b0;
    m_good = 0;
  endtask

  task automatic model_step();
    e_lval = 1'b0;
    e_err  = 1'b0;
    if (reset) begin
      m_mode = 0; m_run = 0; m_remain = 0; m_good = 0;
      m_lock = 1'b0; m_lines = 16'd0; e_pix = 14'd0;
    end else if (!bus.i_start_acquisit) begin
      m_mode = 0; m_run = 0; m_good = 0; m_lock = 1'b0; m_lines = 16'd0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (bus.i_word_valid) begin
      if (m_mode == 1) begin
        if (bus.iv_word == SW) begin
          m_run++;
          if (m_run == 7) begin
            m_run = 0;
            if (bus.iv_line_length == 13'd0) model_err();
            else begin
              m_remain = int'(bus.iv_line_length);
              m_mode = 2;
            end
          end
        end else begin
          if (m_run > 0) model_err();
          m_run = 0;
        end
      end else begin
        if (bus.iv_word == SW) begin
          model_err();
          m_run = 1;
          m_mode = 1;
        end else begin
          e_lval = 1'b1;
          e_pix = bus.iv_word[13:0];
          m_remain--;
          if (m_remain == 0) begin
            m_mode = 1;
            m_lines = m_lines + 16'd1;
            if (m_good < 4) m_good++;
            if (m_good == 4) m_lock = 1'b1;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle compare on the falling edge, away from register updates.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("lval", {31'd0, bus.o_lval}, {31'd0, e_lval});
      chk("sync_err", {31'd0, bus.o_sync_err}, {31'd0, e_err});
      chk("sync_lock", {31'd0, bus.o_sync_lock}, {31'd0, m_lock});
      chk("line_cnt", {16'd0, bus.ov_line_cnt}, {16'd0, m_lines});
      if (e_lval) chk("pix_data", {18'd0, bus.ov_pix_data}, {18'd0, e_pix});
      if (bus.o_lval) begin
        cap.push_back(bus.ov_pix_data);
        lval_seen++;
      end
      if (bus.o_sync_err) err_seen++;
    end
  end

  task automatic send(input logic [15:0] w, input bit v);
    @(negedge clk);
    bus.i_word_valid = v;
    bus.iv_word = w;
  endtask

  task automatic sync_n(input int n);
    for (int i = 0; i < n; i++) send(SW, 1'b1);
  endtask

  function automatic logic [15:0] rpix();
    logic [15:0] w;
    w = 16'($urandom()) & 16'h7FFF;
    return w;
  endfunction

  task automatic rand_line(input int n);
    for (int i = 0; i < n; i++) send(rpix(), 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(16'h0000, 1'b0);
    #1;
  endtask

  logic [15:0] sent[$];
  logic [15:0] w;
  int run_len, dat_len;

  initial begin
    reset = 1'b1;
    bus.i_start_acquisit = 1'b0;
    bus.i_word_valid = 1'b0;
    bus.iv_word = 16'h0000;
    bus.iv_line_length = 13'd64;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pix", {18'd0, bus.ov_pix_data}, 32'd0);
    chk("rst_lval", {31'd0, bus.o_lval}, 32'd0);
    chk("rst_lock", {31'd0, bus.o_sync_lock}, 32'd0);
    chk("rst_err", {31'd0, bus.o_sync_err}, 32'd0);
    chk("rst_lines", {16'd0, bus.ov_line_cnt}, 32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.i_start_acquisit = 1'b1;
    send(16'h0000, 1'b0);

    // One 64-pixel line with ascending data.
    cap.delete(); err_seen = 0;
    sync_n(7);
    for (int i = 0; i < 64; i++) send(16'(i), 1'b1);
    idle(2);
    chk("t1_npix", cap.size(), 32'd64);
    for (int i = 0; i < cap.size(); i++) chk("t1_pix", {18'd0, cap[i]}, i);
    chk("t1_lines", {16'd0, bus.ov_line_cnt}, 32'd1);
    chk("t1_err", err_seen, 32'd0);

    // Three more lines reach lock.
    repeat (3) begin sync_n(7); rand_line(64); end
    idle(2);
    chk("t2_lock", {31'd0, bus.o_sync_lock}, 32'd1);
    chk("t2_lines", {16'd0, bus.ov_line_cnt}, 32'd4);

    // Partial sync run broken by data.
    err_seen = 0; lval_seen = 0;
    sync_n(5); send(16'h0012, 1'b1);
    sync_n(7); rand_line(64);
    idle(2);
    chk("t3_err", err_seen, 32'd1);
    chk("t3_lval", lval_seen, 32'd64);
    chk("t3_lock", {31'd0, bus.o_sync_lock}, 32'd0);
    chk("t3_lines", {16'd0, bus.ov_line_cnt}, 32'd1);

    // Relock, then a premature sync after 30 pixels.
    repeat (3) begin sync_n(7); rand_line(64); end
    idle(1);
    chk("t4_prelock", {31'd0, bus.o_sync_lock}, 32'd1);
    err_seen = 0; lval_seen = 0;
    sync_n(7); rand_line(30); send(SW, 1'b1);
    sync_n(6); rand_line(64);
    idle(2);
    chk("t4_err", err_seen, 32'd1);
    chk("t4_lval", lval_seen, 32'd94);
    chk("t4_lock", {31'd0, bus.o_sync_lock}, 32'd0);
    chk("t4_lines", {16'd0, bus.ov_line_cnt}, 32'd1);

    // Line with invalid-word gaps.
    cap.delete(); sent.delete();
    sync_n(7);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) send(16'($urandom()), 1'b0);
      w = rpix();
      sent.push_back(w);
      send(w, 1'b1);
    end
    idle(2);
    chk("t5_npix", cap.size(), 32'd64);
    for (int i = 0; i < cap.size() && i < 64; i++) chk("t5_pix", {18'd0, cap[i]}, {18'd0, sent[i][13:0]});

    // Acquisition dropped mid-line, then restarted.
    err_seen = 0;
    sync_n(7); rand_line(20);
    @(negedge clk);
    bus.i_start_acquisit = 1'b0;
    bus.i_word_valid = 1'b1;
    bus.iv_word = rpix();
    idle(2);
    chk("t6_lock", {31'd0, bus.o_sync_lock}, 32'd0);
    chk("t6_lval", {31'd0, bus.o_lval}, 32'd0);
    chk("t6_err", err_seen, 32'd0);
    chk("t6_lines", {16'd0, bus.ov_line_cnt}, 32'd0);
    bus.i_start_acquisit = 1'b1;
    send(16'h0000, 1'b0);
    lval_seen = 0;
    sync_n(7); rand_line(64);
    idle(2);
    chk("t6_relval", lval_seen, 32'd64);
    chk("t6_relines", {16'd0, bus.ov_line_cnt}, 32'd1);

    // Zero line length.
    err_seen = 0; lval_seen = 0;
    bus.iv_line_length = 13'd0;
    sync_n(7); rand_line(5);
    idle(2);
    chk("t6_len0_err", err_seen, 32'd1);
    chk("t6_len0_lval", lval_seen, 32'd0);
    bus.iv_line_length = 13'd64;

    // Randomized soak: sync bursts of varying length, short lines, gaps,
    // stray sync words, occasional acquisition drops and resets.
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 9) == 0) bus.iv_line_length = 13'($urandom_range(0, 6));
      run_len = $urandom_range(4, 8);
      dat_len = $urandom_range(0, 10);
      for (int i = 0; i < run_len + dat_len; i++) begin
        @(negedge clk);
        reset = ($urandom_range(0, 299) == 0);
        bus.i_start_acquisit = ($urandom_range(0, 149) != 0);
        bus.i_word_valid = ($urandom_range(0, 4) != 0);
        if (i < run_len) bus.iv_word = SW;
        else if ($urandom_range(0, 7) == 0) bus.iv_word = SW;
        else bus.iv_word = 16'($urandom());
      end
    end
    @(negedge clk);
    reset = 1'b0;
    bus.i_start_acquisit = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
